// File: rtl/alu_muldiv_sequencer_if.sv
// alu_muldiv_sequencer_if: request/result handshake plus shared-ALU drive and return bundle
interface alu_muldiv_sequencer_if #(parameter int WIDTH = 24);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_ctl;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  modport master (
    output start, op, opa, opb, alu_result, alu_cout,
    input  busy, done, div_by_zero, result_hi, result_lo, alu_a, alu_b, alu_ctl, alu_cin
  );
  modport slave (
    input  start, op, opa, opb, alu_result, alu_cout,
    output busy, done, div_by_zero, result_hi, result_lo, alu_a, alu_b, alu_ctl, alu_cin
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: shift-add multiply / restoring divide, one shared-ALU op per cycle
module alu_muldiv_sequencer #(
  parameter int WIDTH = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic             op_q, busy_q, done_q, dbz_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q, res_hi_q, res_lo_q;
  logic             run, sub, mul_c;
  logic [WIDTH-1:0] rs, qs, mul_hi, hi_d, lo_d;
  // hi_q/lo_q hold P_hi/P_lo for multiply and R/Q for divide; m_q is M or D
  always_comb begin
    run     = state_q == RUN;
    rs      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    qs      = {lo_q[WIDTH-2:0], 1'b0};
    bus.alu_a   = run ? (op_q ? rs : hi_q) : '0;
    bus.alu_b   = run ? m_q : '0;
    bus.alu_ctl = run ? (op_q ? 5'b01010 : 5'b00010) : 5'b00000;
    bus.alu_cin = run & op_q;
    mul_hi  = lo_q[0] ? bus.alu_result : hi_q;
    mul_c   = lo_q[0] & bus.alu_cout;
    sub     = hi_q[WIDTH-1] | bus.alu_cout;
    hi_d    = op_q ? (sub ? bus.alu_result : rs) : {mul_c, mul_hi[WIDTH-1:1]};
    lo_d    = op_q ? (qs | {{(WIDTH-1){1'b0}}, sub}) : {mul_hi[0], lo_q[WIDTH-1:1]};
  end
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          op_q   <= bus.op;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          hi_q   <= '0;
          lo_q   <= bus.opa;
          m_q    <= bus.opb;
          if (bus.op && bus.opb == '0) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            dbz_q    <= 1'b1;
            res_hi_q <= bus.opa;
            res_lo_q <= '1;
          end else begin
            state_q <= RUN;
            dbz_q   <= 1'b0;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            res_hi_q <= hi_d;
            res_lo_q <= lo_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer: directed and random multiply/divide against an arithmetic reference
module tb_alu_muldiv_sequencer;
  localparam int W = 24;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  alu_muldiv_sequencer_if #(.WIDTH(W)) bus();
  alu_muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [W-1:0] aa, bb;
  logic [W:0]   s;
  // shared combinational ALU seen by the sequencer
  always_comb begin
    aa = bus.alu_ctl[4] ? ~bus.alu_a : bus.alu_a;
    bb = bus.alu_ctl[3] ? ~bus.alu_b : bus.alu_b;
    s  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, bus.alu_cin};
    bus.alu_cout   = s[W];
    bus.alu_result = bus.alu_ctl[2:0] == 3'b000 ? (aa & bb) :
                     bus.alu_ctl[2:0] == 3'b001 ? (aa | bb) :
                     bus.alu_ctl[2:0] == 3'b010 ? s[W-1:0] :
                     bus.alu_ctl[2:0] == 3'b011 ? {{(W-1){1'b0}}, s[W-1]} : (aa ^ bb);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic z);
    logic [2*W-1:0] p;
    z = 1'b0;
    if (!o) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      hi = p[2*W-1:W];
      lo = p[W-1:0];
    end else if (b == '0) begin
      z  = 1'b1;
      hi = a;
      lo = '1;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic finish_op(input string tag, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] eh, el;
    logic ez;
    model(o, a, b, eh, el, ez);
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), ez ? 64'd1 : 64'(W + 1));
    check({tag, " busy@done"}, 64'(bus.busy), 64'd1);
    check({tag, " hi"}, 64'(bus.result_hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.result_lo), 64'(el));
    check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(ez));
    @(negedge clk);
    check({tag, " idle done/busy/alu"}, {bus.done, bus.busy, bus.alu_ctl, bus.alu_cin, bus.alu_a, bus.alu_b}, 64'd0);
  endtask
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic z;
    z = o && b == '0;
    issue(o, a, b);
    check({tag, " alu_ctl"}, 64'(bus.alu_ctl), z ? 64'd0 : (o ? 64'b01010 : 64'b00010));
    check({tag, " alu_cin"}, 64'(bus.alu_cin), 64'(!z && o));
    check({tag, " alu_a"}, 64'(bus.alu_a), (z || !o) ? 64'd0 : 64'(a >> (W - 1)));
    check({tag, " alu_b"}, 64'(bus.alu_b), z ? 64'd0 : 64'(b));
    finish_op(tag, o, a, b);
  endtask
  initial begin
    int ndone, dcyc, seen;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.opa = '0;
    bus.opb = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus.busy, bus.done, bus.div_by_zero, bus.result_hi, bus.result_lo}, 64'd0);
    check("reset alu", {bus.alu_ctl, bus.alu_cin, bus.alu_a, bus.alu_b}, 64'd0);
    rst_n = 1'b1;
    do_op("mul 3x5", 1'b0, 24'd3, 24'd5);
    check("mul 3x5 const", {bus.result_hi, bus.result_lo}, 64'd15);
    do_op("mul ffffff^2", 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    check("mul ffffff^2 const", {bus.result_hi, bus.result_lo}, 64'hFFFFFE_000001);
    do_op("mul 800000x2", 1'b0, 24'h800000, 24'd2);
    check("mul 800000x2 const", {bus.result_hi, bus.result_lo}, 64'h000001_000000);
    do_op("div 100/7", 1'b1, 24'd100, 24'd7);
    check("div 100/7 const", {bus.result_hi, bus.result_lo}, 64'h000002_00000E);
    do_op("div ffffff/800001", 1'b1, 24'hFFFFFF, 24'h800001);
    check("div ffffff/800001 const", {bus.result_hi, bus.result_lo}, 64'h7FFFFE_000001);
    do_op("div by zero", 1'b1, 24'h123456, 24'd0);
    check("div by zero const", {bus.div_by_zero, bus.result_hi, bus.result_lo}, 64'h1_123456_FFFFFF);
    do_op("mul after dbz", 1'b0, 24'd7, 24'd6);
    // starts at cycles 5 and 25 must be ignored, start at 26 accepted
    issue(1'b0, 24'd3, 24'd5);
    ndone = 0;
    dcyc = 0;
    for (int c = 1; c <= 26; c++) begin
      if (bus.done) begin
        ndone++;
        dcyc = c;
        check("ignore result@done", 64'(bus.result_lo), 64'd15);
      end
      if (c == 26) begin
        check("ignore busy@26", 64'(bus.busy), 64'd0);
        check("ignore held result", {bus.result_hi, bus.result_lo}, 64'd15);
      end
      bus.start = c == 5 || c == 25 || c == 26;
      bus.op = 1'b0;
      bus.opa = 24'd9;
      bus.opb = 24'd9;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ignore done count", 64'(ndone), 64'd1);
    check("ignore done cycle", 64'(dcyc), 64'd25);
    finish_op("start@26 9x9", 1'b0, 24'd9, 24'd9);
    // asynchronous abort in the middle of a multiply
    issue(1'b0, 24'h001234, 24'h000077);
    repeat (9) @(negedge clk);
    check("pre-abort busy", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort outputs", {bus.busy, bus.done, bus.div_by_zero, bus.result_hi, bus.result_lo}, 64'd0);
    check("abort alu", {bus.alu_ctl, bus.alu_cin, bus.alu_a, bus.alu_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen |= int'(bus.done | bus.busy);
    end
    check("no done after abort", 64'(seen), 64'd0);
    do_op("div 100/7 after abort", 1'b1, 24'd100, 24'd7);
    // random operations against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      logic o;
      logic [W-1:0] a, b;
      o = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 :
          ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      do_op("random", o, a, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
